// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_mdu_seq execute unit.
//   alu_op_t - 4-bit operation encoding carried on req_op
//   state_t  - sequencer states of the execute unit
//   FUNCT_*  - MIPS R-type funct field values and their alu_op_t mapping
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_SLTU  = 4'd5,
    OP_RAND  = 4'd6,
    OP_ROR   = 4'd7,
    OP_MULT  = 4'd8,
    OP_MULTU = 4'd9,
    OP_DIV   = 4'd10,
    OP_DIVU  = 4'd11,
    OP_MFHI  = 4'd12,
    OP_MFLO  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2a;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2b;

  // Unrecognised funct values decode to a reserved op so the unit flags err.
  function automatic alu_op_t funct_to_op(input logic [5:0] funct);
    case (funct)
      FUNCT_ADD:   return OP_ADD;
      FUNCT_SUB:   return OP_SUB;
      FUNCT_AND:   return OP_AND;
      FUNCT_OR:    return OP_OR;
      FUNCT_SLT:   return OP_SLT;
      FUNCT_SLTU:  return OP_SLTU;
      FUNCT_MULT:  return OP_MULT;
      FUNCT_MULTU: return OP_MULTU;
      FUNCT_DIV:   return OP_DIV;
      FUNCT_DIVU:  return OP_DIVU;
      FUNCT_MFHI:  return OP_MFHI;
      FUNCT_MFLO:  return OP_MFLO;
      default:     return OP_RSV15;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 iterative unsigned multiply / restoring divide.
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - load operands and run N iterations
//   is_div           - 1: divide op_a by op_b, 0: multiply
//   op_a, op_b       - unsigned magnitudes
//   done             - high during the final iteration cycle
//   res_hi, res_lo   - product {hi,lo} or {remainder,quotient}, valid after done
// Only built when ALU_MDU_EN is defined.
module mdu_iter
  #(parameter int unsigned N = 32)
  (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         done,
  output logic [N-1:0] res_hi,
  output logic [N-1:0] res_lo
  );

  localparam int unsigned CW = $clog2(N) + 1;

  logic [CW-1:0] cnt_q;
  logic          div_q;
  logic [N-1:0]  hi_q, lo_q, opb_q;
  logic [N:0]    add_sum, shifted, trial;

  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, opb_q};
    shifted = {hi_q, lo_q[N-1]};
    trial   = shifted - {1'b0, opb_q};
  end

  assign done   = (cnt_q == CW'(1));
  assign res_hi = hi_q;
  assign res_lo = lo_q;

  // Multiply: lo holds the multiplier and shifts right as product bits land.
  // Divide: lo holds the dividend and shifts left as quotient bits land;
  // a clear borrow bit of trial means the divisor fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(N);
      div_q <= is_div;
      hi_q  <= '0;
      lo_q  <= op_a;
      opb_q <= op_b;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (div_q) begin
        if (!trial[N]) begin
          hi_q <= trial[N-1:0];
          lo_q <= {lo_q[N-2:0], 1'b1};
        end else begin
          hi_q <= shifted[N-1:0];
          lo_q <= {lo_q[N-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {hi_q, lo_q} <= {add_sum, lo_q[N-1:1]};
      end else begin
        {hi_q, lo_q} <= {1'b0, hi_q, lo_q[N-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: N-bit EX-stage execute unit with valid/ready request and
// response channels. Logic/arith ops take one cycle; MULT/MULTU/DIV/DIVU
// iterate for N cycles plus one sign-fix cycle and write HI/LO.
//   clk, rst_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready              - request handshake
//   req_op, req_a, req_b             - operation (alu_op_t) and operands
//   resp_valid/resp_ready            - response handshake
//   resp_result/zero/ovf/err         - result and flags, held until taken
//   hi, lo                           - HI/LO registers
// Build option: ALU_MDU_EN enables multiply/divide and HI/LO; without it
// ops 8-13 are reserved and hi/lo read as zero.
module alu_mdu_seq
  import alu_pkg::*;
  #(parameter int unsigned N = 32)
  (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_result,
  output logic         resp_zero,
  output logic         resp_ovf,
  output logic         resp_err,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
  );

  state_t       state_q;
  alu_op_t      op;
  logic         accept;
  logic [N-1:0] sum, diff;
  logic [N-1:0] sc_result;
  logic         sc_ovf, sc_err;
  logic [N-1:0] result_q;
  logic         zero_q, ovf_q, err_q;

`ifdef ALU_MDU_EN
  logic           sc_mdu;
  logic [N-1:0]   hi_q, lo_q, a_q, b_q;
  logic           sgn_q, div_q;
  logic           is_signed, is_div;
  logic [N-1:0]   mag_a, mag_b;
  logic           mdu_done;
  logic [N-1:0]   it_hi, it_lo;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo, rem, fix_hi, fix_lo;
`endif

  assign op          = alu_op_t'(req_op);
  assign req_ready   = (state_q == ST_IDLE) | ((state_q == ST_RESP) & resp_ready);
  assign accept      = req_valid & req_ready;
  assign sum         = req_a + req_b;
  assign diff        = req_a - req_b;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_ovf    = ovf_q;
  assign resp_err    = err_q;

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
`ifdef ALU_MDU_EN
    sc_mdu    = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (req_a[N-1] == req_b[N-1]) && (sum[N-1] != req_a[N-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (req_a[N-1] != req_b[N-1]) && (diff[N-1] != req_a[N-1]);
      end
      OP_AND:  sc_result = req_a & req_b;
      OP_OR:   sc_result = req_a | req_b;
      OP_SLT:  sc_result = {{(N-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
      OP_SLTU: sc_result = {{(N-1){1'b0}}, (req_a < req_b)};
      OP_RAND: sc_result = req_a & ~req_b;
      OP_ROR:  sc_result = req_a | ~req_b;
`ifdef ALU_MDU_EN
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: sc_mdu = 1'b1;
      OP_MFHI: sc_result = hi_q;
      OP_MFLO: sc_result = lo_q;
`endif
      default: sc_err = 1'b1;
    endcase
  end

`ifdef ALU_MDU_EN
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign mag_a     = (is_signed && req_a[N-1]) ? -req_a : req_a;
  assign mag_b     = (is_signed && req_b[N-1]) ? -req_b : req_b;

  mdu_iter #(.N(N)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && sc_mdu),
    .is_div (is_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .done   (mdu_done),
    .res_hi (it_hi),
    .res_lo (it_lo)
  );

  // Sign correction of the magnitude results; divide-by-zero overrides it
  // so HI returns the original dividend rather than a re-signed magnitude.
  always_comb begin
    prod = {it_hi, it_lo};
    quo  = it_lo;
    rem  = it_hi;
    if (sgn_q && (a_q[N-1] ^ b_q[N-1])) begin
      prod = -prod;
      quo  = -quo;
    end
    if (sgn_q && a_q[N-1]) rem = -rem;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end
    fix_hi = div_q ? rem : prod[2*N-1:N];
    fix_lo = div_q ? quo : prod[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      if (accept && sc_mdu) begin
        a_q   <= req_a;
        b_q   <= req_b;
        sgn_q <= is_signed;
        div_q <= is_div;
      end
      if (state_q == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  assign hi = '0;
  assign lo = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
`ifdef ALU_MDU_EN
        ST_BUSY: if (mdu_done) state_q <= ST_FIX;
        ST_FIX: begin
          state_q  <= ST_RESP;
          result_q <= fix_lo;
          zero_q   <= (fix_lo == '0);
          ovf_q    <= 1'b0;
          err_q    <= 1'b0;
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_MDU_EN
            if (sc_mdu) state_q <= ST_BUSY;
            else
`endif
            begin
              state_q  <= ST_RESP;
              result_q <= sc_result;
              zero_q   <= (sc_result == '0);
              ovf_q    <= sc_ovf;
              err_q    <= sc_err;
            end
          end else if ((state_q == ST_RESP) && resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
module tb_alu_mdu_seq;

  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0]    req_op;
  logic [NB-1:0] req_a, req_b, resp_result, hi, lo;
  logic          resp_zero, resp_ovf, resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_mdu_seq #(.N(NB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_ovf(resp_ovf), .resp_err(resp_err), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic bit mdu_built();
`ifdef ALU_MDU_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model from the operation definitions; updates model HI/LO.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, b,
                                 output logic [31:0] r, output logic ovf, output logic err);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ovf = 1'b0; err = 1'b0;
    if (op >= 4'd8 && op <= 4'd13 && !mdu_built()) begin
      err = 1'b1;
      return;
    end
    case (op)
      4'd0: begin s = sa + sb; r = a + b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; r = a - b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: r = (a < b) ? 32'd1 : 32'd0;
      4'd6: r = a & ~b;
      4'd7: r = a | ~b;
      4'd8: begin s = sa * sb; p = s; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
      4'd9: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
      4'd10: begin
        if (b == 32'd0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
        else begin s = sa / sb; p = s; m_lo = p[31:0]; s = sa % sb; p = s; m_hi = p[31:0]; end
        r = m_lo;
      end
      4'd11: begin
        if (b == 32'd0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        r = m_lo;
      end
      4'd12: r = m_hi;
      4'd13: r = m_lo;
      default: err = 1'b1;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (mdu_built() && op >= 4'd8 && op <= 4'd11) ? NB + 2 : 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one request and wait for its response; lat counts cycles from the
  // accept cycle (1 = response in the next cycle), -1 on timeout.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, output int lat);
    int w;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) lat = -1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_zero, resp_ovf, resp_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got rdy/val/z/o/e=%b required 10000",
               {req_ready, resp_valid, resp_zero, resp_ovf, resp_err});
    end
    n_checks++;
    if ({resp_result, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got result=%h hi=%h lo=%h required 0", resp_result, hi, lo);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    int lat;
    drain();
    do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d required 1", lat); end
    n_checks++;
    if ({resp_result, resp_ovf, resp_zero, resp_err} !== {32'h8000_0000, 3'b100}) begin
      n_fail++;
      $display("FAIL add_ovf got %h o%b z%b e%b required 80000000 o1 z0 e0",
               resp_result, resp_ovf, resp_zero, resp_err);
    end
    do_op(4'd1, 32'd5, 32'd5, lat);
    n_checks++;
    if ({resp_result, resp_ovf, resp_zero, resp_err} !== {32'h0, 3'b010}) begin
      n_fail++;
      $display("FAIL sub_zero got %h o%b z%b e%b required 0 o0 z1 e0",
               resp_result, resp_ovf, resp_zero, resp_err);
    end
  endtask

  task automatic test_slt();
    int lat;
    drain();
    do_op(4'd4, 32'hFFFF_FFFF, 32'd1, lat);
    n_checks++;
    if (resp_result !== 32'd1) begin n_fail++; $display("FAIL slt got %h required 1", resp_result); end
    do_op(4'd5, 32'hFFFF_FFFF, 32'd1, lat);
    n_checks++;
    if (resp_result !== 32'd0 || resp_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sltu got %h z%b required 0 z1", resp_result, resp_zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{4'd0, 4'd3, 4'd1, 4'd6};
    logic [31:0] exp_r;
    logic        eo, ee;
    drain();
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_op = ops[i]; req_a = $urandom; req_b = $urandom;
      ref_op(req_op, req_a, req_b, exp_r, eo, ee);
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b required 1", i, req_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== exp_r) begin
        n_fail++;
        $display("FAIL b2b_resp[%0d] got v%b %h required v1 %h", i, resp_valid, resp_result, exp_r);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] exp_or, exp_add;
    logic eo, ee;
    drain();
    resp_ready = 1'b0;
    ref_op(4'd3, 32'h0F0F_0000, 32'h0000_00F0, exp_or, eo, ee);
    do_op(4'd3, 32'h0F0F_0000, 32'h0000_00F0, lat);
    req_op = 4'd0; req_a = 32'd100; req_b = 32'd23; req_valid = 1'b1;
    ref_op(4'd0, 32'd100, 32'd23, exp_add, eo, ee);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_result !== exp_or || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v%b %h rdy%b required v1 %h rdy0",
                 i, resp_valid, resp_result, req_ready, exp_or);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b required 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_result !== exp_add) begin
      n_fail++;
      $display("FAIL bp_next got v%b %h required v1 %h", resp_valid, resp_result, exp_add);
    end
  endtask

  task automatic test_reserved();
    int lat;
    drain();
    do_op(4'd15, 32'h1234_5678, 32'h9, lat);
    n_checks++;
    if (lat !== 1 || {resp_result, resp_err, resp_zero, resp_ovf} !== {32'h0, 3'b110}) begin
      n_fail++;
      $display("FAIL reserved15 got lat=%0d %h e%b z%b o%b required lat=1 0 e1 z1 o0",
               lat, resp_result, resp_err, resp_zero, resp_ovf);
    end
  endtask

  task automatic test_mdu();
`ifdef ALU_MDU_EN
    logic [3:0]  ops [5] = '{4'd8, 4'd12, 4'd10, 4'd11, 4'd10};
    logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd5, 32'h0, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] eh  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234, 32'h0};
    logic [31:0] el  [5] = '{32'hFFFF_FFF1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] er  [5] = '{32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int          el8 [5] = '{NB + 2, 1, NB + 2, NB + 2, NB + 2};
    int lat;
    logic [31:0] r; logic eo, ee;
    drain();
    for (int i = 0; i < 5; i++) begin
      ref_op(ops[i], as[i], bs[i], r, eo, ee);
      do_op(ops[i], as[i], bs[i], lat);
      n_checks++;
      if (lat !== el8[i] || resp_result !== er[i] || resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL mdu_resp[%0d] got lat=%0d %h e%b required lat=%0d %h e0",
                 i, lat, resp_result, resp_err, el8[i], er[i]);
      end
      n_checks++;
      if (hi !== eh[i] || lo !== el[i]) begin
        n_fail++;
        $display("FAIL mdu_hilo[%0d] got hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, eh[i], el[i]);
      end
    end
`else
    int lat;
    drain();
    do_op(4'd8, 32'hFFFF_FFFD, 32'd5, lat);
    n_checks++;
    if (lat !== 1 || resp_err !== 1'b1 || resp_result !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL mult_disabled got lat=%0d e%b %h hi=%h lo=%h required lat=1 e1 0 hi=0 lo=0",
               lat, resp_err, resp_result, hi, lo);
    end
`endif
  endtask

  task automatic test_random();
    int lat;
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic eo, ee;
    drain();
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick(); b = pick();
      ref_op(op, a, b, r, eo, ee);
      do_op(op, a, b, lat);
      n_checks++;
      if (lat !== exp_lat(op) || {resp_result, resp_zero, resp_ovf, resp_err} !== {r, (r == 32'd0), eo, ee}) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h got lat=%0d %h z%b o%b e%b required lat=%0d %h z%b o%b e%b",
                 i, op, a, b, lat, resp_result, resp_zero, resp_ovf, resp_err,
                 exp_lat(op), r, (r == 32'd0), eo, ee);
      end
      n_checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL rand_hilo[%0d] got hi=%h lo=%h required hi=%h lo=%h", i, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_mid_mdu();
`ifdef ALU_MDU_EN
    int seen;
    int lat;
    drain();
    do_op(4'd9, 32'hDEAD_BEEF, 32'h1234_5678, lat);
    drain();
    req_op = 4'd9; req_a = 32'hFFFF_0001; req_b = 32'h0000_FFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset got hi=%h lo=%h v%b rdy%b required 0 0 v0 rdy1", hi, lo, resp_valid, req_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < NB + 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    n_checks++;
    if (seen !== 0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_after got responses=%0d hi=%h lo=%h required 0 0 0", seen, hi, lo);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_slt();
    test_back_to_back();
    test_backpressure();
    test_reserved();
    test_mdu();
    test_random();
    test_reset_mid_mdu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised successor to the single-cycle datapath ALU: N-bit execute unit with registered valid/ready request and response channels.
- Single-cycle logic/arith ops complete in 1 cycle; MIPS multiply/divide runs iteratively and writes internal HI/LO registers.
- Sits in the EX stage of the multi-cycle/pipelined core; the stall logic consumes req_ready.

Parameters:
- N, 32, operand/result width (>=4).
- CW, $clog2(N)+1, iteration counter width (derived, localparam).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request this cycle
- req_op  in  4  operation, alu_op_t from package
- req_a  in  N  operand A (rs)
- req_b  in  N  operand B (rt/imm)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_result  out  N  result
- resp_zero  out  1  resp_result == 0
- resp_ovf  out  1  signed overflow (ADD/SUB only, else 0)
- resp_err  out  1  illegal/reserved op
- hi  out  N  HI register
- lo  out  N  LO register

Behaviour:
- Ops: ADD 0, SUB 1, AND 2, OR 3, SLT 4 (signed), SLTU 5, RAND 6 (A&~B), ROR 7 (A|~B), MULT 8, MULTU 9, DIV 10, DIVU 11, MFHI 12, MFLO 13; 14-15 reserved.
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_result/hi/lo=0; zero/ovf/err=0. Reset mid-iteration discards the operation and leaves HI/LO at 0.
- FSM: IDLE, BUSY, FIX, RESP.
- req_ready = (state==IDLE) | (state==RESP & resp_ready). Handshake = valid&ready on the same edge.
- Single-cycle op accepted -> RESP next cycle (latency 1); back-to-back throughput 1/cycle while resp_ready=1.
- MULT/MULTU/DIV/DIVU accepted -> BUSY for exactly N cycles (radix-2 shift-add / restoring division on magnitudes), then FIX 1 cycle (sign correction), then RESP. resp_valid asserts N+2 cycles after acceptance. HI/LO are written on the FIX->RESP edge. resp_result = LO for these ops.
- Multiply: {HI,LO} = 2N-bit product (signed for MULT).
- Divide: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
- Divide by zero: LO = all ones, HI = dividend, err=0.
- DIV of most-negative value by -1: LO = most-negative, HI = 0.
- MFHI/MFLO return the HI/LO value current at acceptance, including one written on the same edge the preceding MDU response enters RESP.
- RESP holds all resp_* outputs stable until resp_ready; a RESP->RESP transition on a new accept updates them.
- Reserved op: 1-cycle, result 0, err=1, zero=1.
- SLT/SLTU: result is 1 or 0, zero-extended. ovf is computed per two's-complement sign rules.

Optional Feature:
- Macro ALU_MDU_EN. Defined: ops 8-13 behave as above.
- Undefined: BUSY/FIX states, iteration datapath and HI/LO registers are not built. hi/lo ports are tied 0. Ops 8-13 are treated as reserved (1-cycle, result 0, err=1).

Decomposition:
- Package alu_pkg: alu_op_t enum (4-bit encodings above), state_t enum, and the FUNCT_* to alu_op_t mapping constants used by the decoder.
- Sub-module mdu_iter (N param): start/done interface holding the counter and shift registers for mul/div; the top FSM owns the handshake and the sign fix. Under ALU_MDU_EN only.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, ovf=1, zero=0, resp_valid 1 cycle after accept. SUB 5-5 -> 0, zero=1.
- SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0. Back-to-back 4 ops with resp_ready=1 -> 4 responses on consecutive cycles.
- MULT 0xFFFFFFFD × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1, resp_valid at accept+34. Immediately issue MFHI -> 0xFFFFFFFF.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Backpressure: hold resp_ready=0 for 5 cycles after an OR response -> resp_* stable and req_ready=0; release -> accepted and next request taken the same cycle.
- Assert rst_n low at BUSY cycle 10 of a MULTU -> async clear to IDLE with hi=lo=0 and no response. Reserved op 15 -> err=1; build without ALU_MDU_EN -> op 8 gives err=1, 1-cycle.
